// File: rtl/rec0101_scan_ctrl.sv
// rtl/rec0101_scan_ctrl.sv - truth-table scan sequencer for a 4-input function unit
module rec0101_scan_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [15:0] EXP_MASK      = 16'h7310
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic        vec_x,
    output logic        vec_y,
    output logic        vec_w,
    output logic        vec_z,
    input  logic        dut_s,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic [3:0]  first_err_idx
);

    // Settle counter only has to reach SETTLE_CYCLES-1.
    localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_APPLY  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [15:0]    result_q, result_d;
    logic [4:0]     err_q, err_d;
    logic [3:0]     first_q, first_d;
    logic           pass_q, pass_d;
    logic           scanning;

    // State and status registers; reset returns everything to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= 4'd0;
            cnt_q    <= '0;
            result_q <= 16'd0;
            err_q    <= 5'd0;
            first_q  <= 4'd0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
            first_q  <= first_d;
            pass_q   <= pass_d;
        end
    end

    // Next-state logic: walk idx 0..15, hold each vector, then capture s.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;
        first_d  = first_q;
        pass_d   = pass_q;

        case (state_q)
            S_IDLE: begin
                // abort beats a simultaneous start
                if (!abort && start) begin
                    result_d = 16'd0;
                    err_d    = 5'd0;
                    first_d  = 4'd0;
                    pass_d   = 1'b0;
                    idx_d    = 4'd0;
                    cnt_d    = '0;
                    state_d  = S_APPLY;
                end
            end
            S_APPLY: begin
                if (abort) begin
                    pass_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SAMPLE: begin
                // an abort here drops the sample for this idx
                if (abort) begin
                    pass_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    result_d[idx_q] = dut_s;
                    if (dut_s != EXP_MASK[idx_q]) begin
                        err_d = err_q + 5'd1;
                        if (err_q == 5'd0) begin
                            first_d = idx_q;
                        end
                    end
                    if (idx_q == 4'd15) begin
                        pass_d  = (err_d == 5'd0);
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_APPLY;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state; vector lines idle low.
    always_comb begin
        scanning = (state_q == S_APPLY) || (state_q == S_SAMPLE);
        {vec_x, vec_y, vec_w, vec_z} = scanning ? idx_q : 4'd0;
        busy          = scanning;
        done          = (state_q == S_DONE);
        result        = result_q;
        pass          = pass_q;
        err_count     = err_q;
        first_err_idx = first_q;
    end

endmodule

// File: tb/tb_rec0101_scan_ctrl.sv
// tb/tb_rec0101_scan_ctrl.sv - self-checking bench for rec0101_scan_ctrl
module tb_rec0101_scan_ctrl;

    localparam logic [15:0] MASK = 16'h7310;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start0, abort0, start1, abort1;
    logic [15:0] tt;
    logic        sel;

    logic        x0, y0, w0, z0, s0, busy0, done0, pass0;
    logic [15:0] res0;
    logic [4:0]  err0;
    logic [3:0]  fst0;
    logic        x1, y1, w1, z1, s1, busy1, done1, pass1;
    logic [15:0] res1;
    logic [4:0]  err1;
    logic [3:0]  fst1;

    logic [3:0] vec0, vec1;
    assign vec0 = {x0, y0, w0, z0};
    assign vec1 = {x1, y1, w1, z1};
    // behavioural function unit: truth table lookup
    assign s0 = tt[vec0];
    assign s1 = tt[vec1];

    rec0101_scan_ctrl #(.SETTLE_CYCLES(1), .EXP_MASK(MASK)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .vec_x(x0), .vec_y(y0), .vec_w(w0), .vec_z(z0), .dut_s(s0),
        .busy(busy0), .done(done0), .result(res0), .pass(pass0),
        .err_count(err0), .first_err_idx(fst0));

    rec0101_scan_ctrl #(.SETTLE_CYCLES(3), .EXP_MASK(MASK)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .vec_x(x1), .vec_y(y1), .vec_w(w1), .vec_z(z1), .dut_s(s1),
        .busy(busy1), .done(done1), .result(res1), .pass(pass1),
        .err_count(err1), .first_err_idx(fst1));

    logic [3:0]  m_vec;
    logic        m_busy, m_done, m_pass;
    logic [15:0] m_res;
    logic [4:0]  m_err;
    logic [3:0]  m_fst;
    assign m_vec  = sel ? vec1  : vec0;
    assign m_busy = sel ? busy1 : busy0;
    assign m_done = sel ? done1 : done0;
    assign m_pass = sel ? pass1 : pass0;
    assign m_res  = sel ? res1  : res0;
    assign m_err  = sel ? err1  : err0;
    assign m_fst  = sel ? fst1  : fst0;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] t;
        logic [15:0] e_res;
        logic        e_pass;
        logic [4:0]  e_err;
        logic [3:0]  e_fst;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int ref_errs(input logic [15:0] t);
        int n = 0;
        for (int i = 0; i < 16; i++) if (t[i] != MASK[i]) n++;
        return n;
    endfunction

    function automatic int ref_first(input logic [15:0] t);
        for (int i = 0; i < 16; i++) if (t[i] != MASK[i]) return i;
        return 0;
    endfunction

    task automatic set_start(input logic v);
        if (sel) start1 = v; else start0 = v;
    endtask

    task automatic set_abort(input logic v);
        if (sel) abort1 = v; else abort0 = v;
    endtask

    task automatic check_status(input string tag, input logic [15:0] t);
        check({tag, "_result"}, 32'(m_res), 32'(t));
        check({tag, "_pass"},   32'(m_pass), 32'(t == MASK));
        check({tag, "_errs"},   32'(m_err), 32'(ref_errs(t)));
        check({tag, "_first"},  32'(m_fst), 32'(ref_first(t)));
    endtask

    // Full scan on the selected unit; optional start poke at cycle poke_c.
    task automatic run_scan(input int settle, input logic [15:0] t, input int poke_c);
        int n;
        int vbad;
        int bbad;
        n = 16 * (settle + 1);
        vbad = 0;
        bbad = 0;
        tt = t;
        @(negedge clk);
        set_start(1'b1);
        @(posedge clk);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            set_start(c == poke_c);
            if (m_vec !== 4'((c - 1) / (settle + 1))) vbad++;
            if (m_busy !== 1'b1 || m_done !== 1'b0) bbad++;
        end
        @(negedge clk);
        set_start(1'b0);
        check("vec_sequence", 32'(vbad), 32'd0);
        check("busy_during_scan", 32'(bbad), 32'd0);
        check("done_at_latency", 32'(m_done), 32'd1);
        check("busy_at_done", 32'(m_busy), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(m_done), 32'd0);
        check("vec_idle", 32'(m_vec), 32'd0);
    endtask

    initial begin
        logic [15:0] r;
        int nodone;

        tbl[0] = '{16'h7310, 16'h7310, 1'b1, 5'd0,  4'd0};
        tbl[1] = '{16'h0000, 16'h0000, 1'b0, 5'd6,  4'd4};
        tbl[2] = '{16'h8CEF, 16'h8CEF, 1'b0, 5'd16, 4'd0};
        tbl[3] = '{16'hFFFF, 16'hFFFF, 1'b0, 5'd10, 4'd0};
        tbl[4] = '{16'h7311, 16'h7311, 1'b0, 5'd1,  4'd0};
        tbl[5] = '{16'hF310, 16'hF310, 1'b0, 5'd1,  4'd15};

        sel = 1'b0;
        start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        tt = MASK;
        rst_n = 1'b0;
        #1;
        check("reset_outputs", {vec0, busy0, done0, pass0, err0, fst0, res0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // table-driven scans on the SETTLE_CYCLES=1 unit
        for (int i = 0; i < 6; i++) begin
            run_scan(1, tbl[i].t, 0);
            check("tbl_result", 32'(m_res),  32'(tbl[i].e_res));
            check("tbl_pass",   32'(m_pass), 32'(tbl[i].e_pass));
            check("tbl_errs",   32'(m_err),  32'(tbl[i].e_err));
            check("tbl_first",  32'(m_fst),  32'(tbl[i].e_fst));
        end

        // random truth tables against the reference model
        for (int i = 0; i < 6; i++) begin
            r = 16'($urandom);
            run_scan(1, r, 0);
            check_status("rand0", r);
        end

        // abort while idx=7 (sample cycle): bit 7 and above stay clear
        tt = 16'h8CEF;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            start0 = 1'b0;
            abort0 = (c == 16);
        end
        @(negedge clk);
        abort0 = 1'b0;
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_vec", 32'(vec0), 32'd0);
        check("abort_pass", 32'(pass0), 32'd0);
        check("abort_result", 32'(res0), 32'h006F);
        check("abort_errs", 32'(err0), 32'd7);
        nodone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done0 !== 1'b0 || busy0 !== 1'b0) nodone++;
        end
        check("abort_no_done", 32'(nodone), 32'd0);
        run_scan(1, MASK, 0);
        check_status("after_abort", MASK);

        // abort and start together in IDLE: stays idle, results untouched
        @(negedge clk);
        start0 = 1'b1;
        abort0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        abort0 = 1'b0;
        check("abort_start_idle", 32'(busy0), 32'd0);
        check("abort_start_hold", 32'(res0), 32'(MASK));

        // SETTLE_CYCLES=3 unit: start pulse at idx=3 is ignored
        sel = 1'b1;
        run_scan(3, MASK, 14);
        check_status("settle3", MASK);
        for (int i = 0; i < 2; i++) begin
            r = 16'($urandom);
            run_scan(3, r, 0);
            check_status("rand1", r);
        end

        // asynchronous reset mid-scan
        sel = 1'b0;
        tt = 16'h8CEF;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midscan_reset", {vec0, busy0, done0, pass0, err0, fst0, res0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_scan(1, 16'h0000, 0);
        check_status("post_reset", 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
